// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of mem_port_arbiter: per-requester request fields, grants and
// the one-hot read response with its shared data bus.
interface mem_port_arbiter_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*DEPTH-1:0] req_addr;
    logic [NREQ*WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one simple dual-port memory (1-cycle read, 1 write) among NREQ clients.
// Optional zero-fill sweep FSM enabled by defining MEM_ARB_CLEAR_EN.
module mem_port_arbiter #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter int NREQ  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    req_if,
    input  logic                 clear_req_i,
    output logic                 busy_o,
    output logic [DEPTH-1:0]     mem_read_addr_o,
    output logic [DEPTH-1:0]     mem_write_addr_o,
    output logic                 mem_we_o,
    output logic [WIDTH-1:0]     mem_wdata_o,
    input  logic [WIDTH-1:0]     mem_rdata_i
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    logic [IW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [IW-1:0]    rd_idx, wr_idx;
    logic             rd_found, wr_found;
    logic             run_en, rd_gnt_en, wr_gnt_en;
    logic [NREQ-1:0]  rd_cand, wr_cand, rd_oh, wr_oh;
    logic [DEPTH-1:0] sweep_addr;

    logic             rsp_vld_q;
    logic [IW-1:0]    rsp_idx_q;
    logic             byp_q;
    logic [WIDTH-1:0] byp_data_q;

`ifdef MEM_ARB_CLEAR_EN
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [DEPTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + DEPTH'(1);
            if (&cnt_q) state_d = ST_RUN;
        end else if (clear_req_i) begin
            state_d = ST_CLEAR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign sweep_addr = cnt_q;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req_i;
    assign busy_o           = 1'b0;
    assign sweep_addr       = '0;
`endif

    // Grants are gated by rst_n so nothing is offered while reset is asserted.
    assign run_en  = rst_n & ~busy_o;
    assign rd_cand = req_if.req_valid & ~req_if.req_we;
    assign wr_cand = req_if.req_valid &  req_if.req_we;

    always_comb begin
        logic [IW:0] rs, ws;
        rd_found = 1'b0;
        wr_found = 1'b0;
        rd_idx   = rd_ptr_q;
        wr_idx   = wr_ptr_q;
        rs       = '0;
        ws       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rs = {1'b0, rd_ptr_q} + (IW+1)'(k);
            if (rs >= (IW+1)'(NREQ)) rs = rs - (IW+1)'(NREQ);
            ws = {1'b0, wr_ptr_q} + (IW+1)'(k);
            if (ws >= (IW+1)'(NREQ)) ws = ws - (IW+1)'(NREQ);
            if (!rd_found && rd_cand[rs[IW-1:0]]) begin
                rd_found = 1'b1;
                rd_idx   = rs[IW-1:0];
            end
            if (!wr_found && wr_cand[ws[IW-1:0]]) begin
                wr_found = 1'b1;
                wr_idx   = ws[IW-1:0];
            end
        end
    end

    assign rd_gnt_en = run_en & rd_found;
    assign wr_gnt_en = run_en & wr_found;
    assign rd_oh     = rd_gnt_en ? (NREQ'(1) << rd_idx) : '0;
    assign wr_oh     = wr_gnt_en ? (NREQ'(1) << wr_idx) : '0;

    assign req_if.req_ready = rd_oh | wr_oh;
    assign mem_read_addr_o  = rd_gnt_en ? req_if.req_addr[rd_idx*DEPTH +: DEPTH] : '0;

    always_comb begin
        mem_we_o         = 1'b0;
        mem_write_addr_o = '0;
        mem_wdata_o      = '0;
        if (rst_n && busy_o) begin
            mem_we_o         = 1'b1;
            mem_write_addr_o = sweep_addr;
        end else if (wr_gnt_en) begin
            mem_we_o         = 1'b1;
            mem_write_addr_o = req_if.req_addr[wr_idx*DEPTH +: DEPTH];
            mem_wdata_o      = req_if.req_wdata[wr_idx*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= LAST;
            wr_ptr_q  <= LAST;
            rsp_vld_q <= 1'b0;
            byp_q     <= 1'b0;
        end else begin
            if (rd_gnt_en) rd_ptr_q <= rd_idx;
            if (wr_gnt_en) wr_ptr_q <= wr_idx;
            rsp_vld_q <= rd_gnt_en;
            byp_q     <= rd_gnt_en & mem_we_o & (mem_write_addr_o == mem_read_addr_o);
        end
    end

    // Memory returns old data on a same-address collision; forward the written word instead.
    always_ff @(posedge clk) begin
        rsp_idx_q  <= rd_idx;
        byp_data_q <= mem_wdata_o;
    end

    assign req_if.rsp_valid = rsp_vld_q ? (NREQ'(1) << rsp_idx_q) : '0;
    assign req_if.rsp_rdata = byp_q ? byp_data_q : mem_rdata_i;

endmodule
